// File: rtl/risc_pkg.sv
// Shared sequencer types and default vectors for the PC sequencer and related blocks.
package risc_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ISR    = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

  localparam int unsigned DEF_INC     = 4;
  localparam logic [31:0] DEF_RST_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_INT_VEC = 32'h0000_0100;

endpackage

// File: rtl/ret_stack.sv
// Circular return-address LIFO; pushing when full silently overwrites the oldest entry.
module ret_stack #(
  parameter int AW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [AW-1:0]              push_data,
  output logic [AW-1:0]              pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = $clog2(DEPTH+1);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] top_reg;
  logic [PW-1:0] rd_ptr;
  logic [DW-1:0] cnt_reg;

  // top_reg is the next free slot, so the newest entry sits one below it
  assign rd_ptr   = top_reg - PW'(1);
  assign pop_data = mem[rd_ptr];
  assign full     = (cnt_reg == DW'(DEPTH));
  assign empty    = (cnt_reg == '0);
  assign depth    = cnt_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[top_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_reg <= '0;
      cnt_reg <= '0;
    end else if (push) begin
      top_reg <= top_reg + PW'(1);
      if (!full) begin
        cnt_reg <= cnt_reg + DW'(1);
      end
    end else if (pop && !empty) begin
      top_reg <= rd_ptr;
      cnt_reg <= cnt_reg - DW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: branches, call/return stack, single-level interrupt and halt.
module pc_sequencer
  import risc_pkg::*;
#(
  parameter int            AW      = 32,
  parameter int            DEPTH   = 8,
  parameter int            INC     = DEF_INC,
  parameter logic [AW-1:0] RST_VEC = AW'(DEF_RST_VEC),
  parameter logic [AW-1:0] INT_VEC = AW'(DEF_INT_VEC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       upd_pc,
  input  logic                       br_taken,
  input  logic [AW-1:0]              br_target,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       int_req,
  input  logic                       iret,
  input  logic                       halt,
  output logic [AW-1:0]              pc,
  output logic [AW-1:0]              npc,
  output logic                       int_ack,
  output logic                       in_isr,
  output logic                       stk_ovf,
  output logic                       stk_unf,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  seq_state_t    state_reg, state_next;
  logic [AW-1:0] pc_reg, pc_next;
  logic [AW-1:0] epc_reg, epc_next;
  logic          ack_reg, ack_next;
  logic          ovf_reg, ovf_next;
  logic          unf_reg, unf_next;

  logic          stk_push, stk_pop;
  logic [AW-1:0] stk_data;
  logic          stk_full, stk_empty;

  ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (npc),
    .pop_data  (stk_data),
    .full      (stk_full),
    .empty     (stk_empty),
    .depth     (depth)
  );

  assign npc     = pc_reg + AW'(INC);
  assign pc      = pc_reg;
  assign int_ack = ack_reg;
  assign in_isr  = (state_reg == ISR);
  assign stk_ovf = ovf_reg;
  assign stk_unf = unf_reg;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    epc_next   = epc_reg;
    ack_next   = 1'b0;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;

    if (state_reg == HALTED) begin
      // Wake does not need upd_pc; the halted instruction is treated as retired
      if (int_req) begin
        epc_next   = npc;
        pc_next    = INT_VEC;
        state_next = ISR;
        ack_next   = 1'b1;
      end
    end else if (upd_pc) begin
      if (state_reg == RUN && int_req) begin
        epc_next   = pc_reg;
        pc_next    = INT_VEC;
        state_next = ISR;
        ack_next   = 1'b1;
      end else if (iret && state_reg == ISR) begin
        pc_next    = epc_reg;
        state_next = RUN;
      end else if (ret) begin
        if (stk_empty) begin
          pc_next  = npc;
          unf_next = 1'b1;
        end else begin
          stk_pop = 1'b1;
          pc_next = stk_data;
        end
      end else if (call) begin
        stk_push = 1'b1;
        pc_next  = br_target;
        if (stk_full) begin
          ovf_next = 1'b1;
        end
      end else if (br_taken) begin
        pc_next = br_target;
      end else if (halt) begin
        state_next = HALTED;
      end else begin
        pc_next = npc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      pc_reg    <= RST_VEC;
      epc_reg   <= '0;
      ack_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      epc_reg   <= epc_next;
      ack_reg   <= ack_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (AW=32, DEPTH=4, INC=4, INT_VEC=0x100).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd_pc, br_taken, call, ret, int_req, iret, halt;
  logic [31:0] br_target;
  logic [31:0] pc, npc;
  logic        int_ack, in_isr, stk_ovf, stk_unf;
  logic [2:0]  depth;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .AW      (32),
    .DEPTH   (4),
    .INC     (4),
    .RST_VEC (32'h0),
    .INT_VEC (32'h100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .upd_pc    (upd_pc),
    .br_taken  (br_taken),
    .br_target (br_target),
    .call      (call),
    .ret       (ret),
    .int_req   (int_req),
    .iret      (iret),
    .halt      (halt),
    .pc        (pc),
    .npc       (npc),
    .int_ack   (int_ack),
    .in_isr    (in_isr),
    .stk_ovf   (stk_ovf),
    .stk_unf   (stk_unf),
    .depth     (depth)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    upd_pc = 1'b0; br_taken = 1'b0; call = 1'b0; ret = 1'b0;
    int_req = 1'b0; iret = 1'b0; halt = 1'b0; br_target = 32'h0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_pc", pc, 32'h0);
    chk("rst_depth", 32'(depth), 32'h0);
    chk("rst_isr", 32'(in_isr), 32'h0);
    chk("rst_ack", 32'(int_ack), 32'h0);
    chk("rst_ovf", 32'(stk_ovf), 32'h0);
    chk("rst_unf", 32'(stk_unf), 32'h0);

    // Sequential stepping
    upd_pc = 1'b1;
    tick(); chk("seq_pc1", pc, 32'h4);
    tick(); chk("seq_pc2", pc, 32'h8);
    tick(); chk("seq_pc3", pc, 32'hC);
    chk("seq_npc", npc, 32'h10);
    $display("txn seq: pc=%h npc=%h", pc, npc);

    // Without upd_pc nothing moves and int_req is not sampled
    upd_pc = 1'b0; int_req = 1'b1;
    tick();
    chk("hold_pc", pc, 32'hC);
    chk("hold_ack", 32'(int_ack), 32'h0);
    chk("hold_isr", 32'(in_isr), 32'h0);
    int_req = 1'b0;

    // Call then return from pc=0x8
    do_reset();
    upd_pc = 1'b1;
    tick(); tick();
    chk("cr_start", pc, 32'h8);
    call = 1'b1; br_target = 32'h40;
    tick();
    chk("call_pc", pc, 32'h40);
    chk("call_depth", 32'(depth), 32'h1);
    call = 1'b0; ret = 1'b1;
    tick();
    chk("ret_pc", pc, 32'hC);
    chk("ret_depth", 32'(depth), 32'h0);
    ret = 1'b0;
    $display("txn call/ret: pc=%h depth=%0d", pc, depth);

    // Overflow: calls placed at 0x20..0x60 push 0x24..0x64, oldest (0x24) dropped
    do_reset();
    upd_pc = 1'b1; br_taken = 1'b1; br_target = 32'h20;
    tick();
    chk("ovf_br", pc, 32'h20);
    br_taken = 1'b0; call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      br_target = 32'h30 + 32'(i) * 32'h10;
      tick();
    end
    chk("ovf_pc", pc, 32'h70);
    chk("ovf_flag", 32'(stk_ovf), 32'h1);
    chk("ovf_depth", 32'(depth), 32'h4);
    call = 1'b0; ret = 1'b1;
    tick(); chk("pop1", pc, 32'h64);
    tick(); chk("pop2", pc, 32'h54);
    tick(); chk("pop3", pc, 32'h44);
    tick(); chk("pop4", pc, 32'h34);
    chk("pop_depth", 32'(depth), 32'h0);
    chk("pop_unf_clear", 32'(stk_unf), 32'h0);
    tick();
    chk("unf_pc", pc, 32'h38);
    chk("unf_flag", 32'(stk_unf), 32'h1);
    chk("unf_depth", 32'(depth), 32'h0);
    chk("ovf_sticky", 32'(stk_ovf), 32'h1);
    ret = 1'b0;
    $display("txn ovf/unf: pc=%h ovf=%b unf=%b", pc, stk_ovf, stk_unf);

    // Interrupt overrides a simultaneous call
    do_reset();
    upd_pc = 1'b1;
    tick(); tick(); tick(); tick();
    chk("int_start", pc, 32'h10);
    int_req = 1'b1; call = 1'b1; br_target = 32'h200;
    tick();
    chk("int_pc", pc, 32'h100);
    chk("int_ack", 32'(int_ack), 32'h1);
    chk("int_isr", 32'(in_isr), 32'h1);
    chk("int_depth", 32'(depth), 32'h0);
    call = 1'b0;
    tick();
    chk("nest_pc", pc, 32'h104);
    chk("nest_ack", 32'(int_ack), 32'h0);
    chk("nest_isr", 32'(in_isr), 32'h1);
    int_req = 1'b0; iret = 1'b1;
    tick();
    chk("iret_pc", pc, 32'h10);
    chk("iret_isr", 32'(in_isr), 32'h0);
    iret = 1'b0;
    $display("txn int: pc=%h in_isr=%b", pc, in_isr);

    // Halt at 0x20, wake by interrupt without upd_pc, return to 0x24
    br_taken = 1'b1; br_target = 32'h20;
    tick();
    br_taken = 1'b0; halt = 1'b1;
    tick();
    chk("halt_pc", pc, 32'h20);
    halt = 1'b0;
    tick(); tick(); tick();
    chk("halt_idle_pc", pc, 32'h20);
    chk("halt_isr", 32'(in_isr), 32'h0);
    upd_pc = 1'b0; int_req = 1'b1;
    tick();
    chk("wake_pc", pc, 32'h100);
    chk("wake_ack", 32'(int_ack), 32'h1);
    chk("wake_isr", 32'(in_isr), 32'h1);
    int_req = 1'b0; upd_pc = 1'b1; iret = 1'b1;
    tick();
    chk("wake_iret_pc", pc, 32'h24);
    iret = 1'b0;
    $display("txn halt: pc=%h", pc);

    // npc wraps modulo 2^32
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    tick();
    chk("wrap_npc", npc, 32'h0);
    br_taken = 1'b0;
    tick();
    chk("wrap_pc", pc, 32'h0);

    // Reset abandons ISR and discards the stack
    do_reset();
    upd_pc = 1'b1; call = 1'b1; br_target = 32'h40;
    tick();
    br_target = 32'h50;
    tick();
    call = 1'b0; int_req = 1'b1;
    tick();
    chk("pre_rst_depth", 32'(depth), 32'h2);
    chk("pre_rst_isr", 32'(in_isr), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0; idle();
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_isr", 32'(in_isr), 32'h0);
    chk("mid_rst_depth", 32'(depth), 32'h0);
    chk("mid_rst_ack", 32'(int_ack), 32'h0);
    chk("mid_rst_flags", {30'h0, stk_ovf, stk_unf}, 32'h0);
    $display("txn rst-in-isr: pc=%h depth=%0d", pc, depth);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
